ddr3_rw_arbiter: RTL
====================

DDR3_RW_ARBITER -- requirements
Module: ddr3_rw_arbiter

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- ADDR_WIDTH, 27, DDR3 app address width.
- BURST_BEATS, 8, 128-bit beats per burst.
- ADDR_STEP, 64, address increment per burst, in 16-bit words.
- MAX_ADDR, 172800, frame size in 16-bit words.
REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- ref_clk, in, 1, sole clock.
- rst_n, in, 1, reset: one clock; reset is asynchronous and active-low.
- init_done, in, 1, DDR3 calibration complete.
- wr_req, in, 1, write FIFO holds at least BURST_BEATS words.
- wr_load, in, 1, write frame restart pulse, already synchronous to ref_clk.
- rd_req, in, 1, read FIFO has room for BURST_BEATS words.
- rd_load, in, 1, read frame restart pulse, already synchronous to ref_clk.
- wr_fifo_rd_en, out, 1, pop the write FIFO.
- wr_fifo_data, in, 128, write FIFO data, first-word-fall-through.
- rd_fifo_wr_en, out, 1, push the read FIFO.
- rd_fifo_data, out, 128, read FIFO data.
- cmd, out, 3, DDR3 command: 3'b000 = write, 3'b001 = read.
- cmd_en, out, 1, command strobe.
- cmd_rdy, in, 1, DDR3 IP accepts a command.
- addr, out, ADDR_WIDTH, burst start address.
- ddr3_wr_data, out, 128, write data to the DDR3 IP.
- ddr3_wren, out, 1, write beat valid.
- ddr3_wr_end, out, 1, last write beat of the burst.
- ddr3_wr_rdy, in, 1, DDR3 IP accepts write data.
- ddr3_burst_number, out, 6, beats per burst minus 1.
- ddr3_rd_data, in, 128, read data from the DDR3 IP.
- ddr3_rd_valid, in, 1, read beat valid.
- busy, out, 1, FSM not in IDLE.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT.
REQ-004 In IDLE with init_done low, the FSM SHALL remain in IDLE and ignore wr_req and rd_req.
REQ-005 In IDLE with init_done high, arbitration SHALL be round-robin:
- wr_req only -> WR_CMD.
- rd_req only -> RD_CMD.
- both requesting -> grant the direction not served last.
- last_served resets to "read", so the first contested grant goes to write.
REQ-006 In WR_CMD and RD_CMD, cmd_en SHALL pulse for exactly the one cycle in which cmd_rdy is high, then the FSM SHALL advance to WR_DATA or RD_WAIT respectively.
- cmd and addr SHALL be stable throughout the CMD state.
- If cmd_rdy never rises, the FSM SHALL wait indefinitely with cmd_en low.
REQ-007 In WR_DATA, ddr3_wren and wr_fifo_rd_en SHALL both equal ddr3_wr_rdy, and ddr3_wr_data SHALL equal wr_fifo_data combinationally.
REQ-008 A beat counter SHALL count accepted write beats; ddr3_wr_end SHALL be high on the BURST_BEATS-th accepted beat only, after which the FSM SHALL return to IDLE.
REQ-009 In RD_WAIT, rd_fifo_wr_en SHALL equal ddr3_rd_valid and rd_fifo_data SHALL equal ddr3_rd_data.
- After the BURST_BEATS-th valid beat, the FSM SHALL return to IDLE.
- ddr3_rd_valid outside RD_WAIT SHALL be ignored: no FIFO push.
REQ-010 ddr3_burst_number SHALL be the constant BURST_BEATS-1 (7 at defaults).
REQ-011 Separate write and read address registers SHALL be kept.
- After a completed burst, the register for that direction SHALL advance by ADDR_STEP.
- If the advanced value is >= MAX_ADDR, the register SHALL wrap to 0.
- At defaults the last burst starts at 172736, followed by 0.
REQ-012 addr SHALL show the write address register in WR_CMD and the read address register in RD_CMD; it SHALL be 0 in other states.
REQ-013 When wr_load or rd_load arrives while that direction is idle, its address register SHALL clear to 0 on the next edge.
REQ-014 When a load arrives mid-burst of the same direction:
- the load SHALL be latched pending;
- at burst completion the register SHALL be set to 0 instead of being advanced;
- the pending flag SHALL then clear.
- A load coinciding with the final beat SHALL also produce 0.
REQ-015 No burst SHALL be aborted or truncated by wr_load, rd_load, a req deassertion, or init_done falling.
- init_done low SHALL only block new grants from IDLE.
REQ-016 busy SHALL be high in every state except IDLE.

Reset
REQ-017 On rst_n low, the block SHALL reset asynchronously as follows:
- FSM state = IDLE.
- cmd_en, ddr3_wren, ddr3_wr_end, wr_fifo_rd_en, rd_fifo_wr_en, busy = 0.
- cmd = 3'b000, addr = 0.
- Both address registers, both beat counters and both pending-load flags = 0.
- last_served = read.
REQ-018 Reset asserted mid-burst SHALL abandon the burst immediately; after release the block SHALL restart from IDLE with addresses 0.

Verification
REQ-019 Bench scenario, single write: init_done=1, wr_req=1, cmd_rdy held 1, ddr3_wr_rdy=1 -> one cmd_en with cmd=000 and addr=0, then 8 consecutive wren, wr_end on beat 8, next write at addr=64.
REQ-020 Bench scenario, contested requests: wr_req and rd_req both held high -> grants alternate W,R,W,R; write addresses 0,64,...; read addresses 0,64,....
REQ-021 Bench scenario, backpressure: ddr3_wr_rdy toggling 1010... during WR_DATA -> exactly 8 FIFO pops, no pop while ddr3_wr_rdy=0, wr_end on the 8th accepted beat.
REQ-022 Bench scenario, wrap and load: run 2700 write bursts -> the 2701st write burst uses addr 0; a wr_load pulse during beat 4 of a burst at addr 6400 -> next write burst at addr 0.
REQ-023 Bench scenario, init and reset: init_done=0 with both reqs high -> no cmd_en for 100 cycles; rst_n pulsed low during RD_WAIT -> all outputs 0 in the same cycle, busy=0, next read at addr 0.

Source files
------------

// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: round-robin DDR3 read/write burst arbiter with per-direction frame address generation
module ddr3_rw_arbiter #(
  parameter int ADDR_WIDTH  = 27,
  parameter int BURST_BEATS = 8,
  parameter int ADDR_STEP   = 64,
  parameter int MAX_ADDR    = 172800
) (
  input  logic                  ref_clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  wr_req,
  input  logic                  wr_load,
  input  logic                  rd_req,
  input  logic                  rd_load,
  output logic                  wr_fifo_rd_en,
  input  logic [127:0]          wr_fifo_data,
  output logic                  rd_fifo_wr_en,
  output logic [127:0]          rd_fifo_data,
  output logic [2:0]            cmd,
  output logic                  cmd_en,
  input  logic                  cmd_rdy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [127:0]          ddr3_wr_data,
  output logic                  ddr3_wren,
  output logic                  ddr3_wr_end,
  input  logic                  ddr3_wr_rdy,
  output logic [5:0]            ddr3_burst_number,
  input  logic [127:0]          ddr3_rd_data,
  input  logic                  ddr3_rd_valid,
  output logic                  busy
);
  localparam int CW = $clog2(BURST_BEATS + 1);
  localparam logic [CW-1:0] LAST = CW'(BURST_BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(MAX_ADDR);
  typedef enum logic [2:0] {IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT} state_t;
  state_t state_q, state_d;
  logic last_rd_q, last_rd_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, wr_next, rd_next;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;
  logic wr_beat, rd_beat, wr_done, rd_done, wr_active, rd_active;
  assign wr_beat = state_q == WR_DATA && ddr3_wr_rdy;
  assign rd_beat = state_q == RD_WAIT && ddr3_rd_valid;
  assign wr_done = wr_beat && wr_cnt_q == LAST;
  assign rd_done = rd_beat && rd_cnt_q == LAST;
  assign wr_active = state_q == WR_CMD || state_q == WR_DATA;
  assign rd_active = state_q == RD_CMD || state_q == RD_WAIT;
  assign wr_next = wr_addr_q + STEP;
  assign rd_next = rd_addr_q + STEP;
  assign busy = state_q != IDLE;
  assign cmd_en = (state_q == WR_CMD || state_q == RD_CMD) && cmd_rdy;
  assign cmd = state_q == RD_CMD ? 3'b001 : 3'b000;
  assign addr = state_q == WR_CMD ? wr_addr_q : state_q == RD_CMD ? rd_addr_q : '0;
  assign ddr3_wren = wr_beat;
  assign wr_fifo_rd_en = wr_beat;
  assign ddr3_wr_end = wr_done;
  assign ddr3_wr_data = state_q == WR_DATA ? wr_fifo_data : '0;
  assign rd_fifo_wr_en = rd_beat;
  assign rd_fifo_data = state_q == RD_WAIT ? ddr3_rd_data : '0;
  assign ddr3_burst_number = 6'(BURST_BEATS - 1);
  // Next state: round-robin grant from IDLE, bursts always run to completion
  always_comb begin
    state_d = state_q;
    last_rd_d = last_rd_q;
    case (state_q)
      IDLE:
        if (init_done && wr_req && (!rd_req || last_rd_q)) begin
          state_d = WR_CMD;
          last_rd_d = 1'b0;
        end else if (init_done && rd_req) begin
          state_d = RD_CMD;
          last_rd_d = 1'b1;
        end
      WR_CMD:  state_d = cmd_rdy ? WR_DATA : WR_CMD;
      WR_DATA: state_d = wr_done ? IDLE : WR_DATA;
      RD_CMD:  state_d = cmd_rdy ? RD_WAIT : RD_CMD;
      RD_WAIT: state_d = rd_done ? IDLE : RD_WAIT;
      default: state_d = IDLE;
    endcase
  end
  // Beat counters and addresses; a load during a burst is deferred so addr stays stable
  always_comb begin
    wr_cnt_d = wr_beat ? (wr_done ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
    rd_cnt_d = rd_beat ? (rd_done ? '0 : rd_cnt_q + 1'b1) : rd_cnt_q;
    wr_pend_d = wr_done ? 1'b0 : wr_pend_q || (wr_load && wr_active);
    rd_pend_d = rd_done ? 1'b0 : rd_pend_q || (rd_load && rd_active);
    wr_addr_d = wr_done ? ((wr_pend_q || wr_load || wr_next >= TOP) ? '0 : wr_next)
              : (wr_load && !wr_active) ? '0 : wr_addr_q;
    rd_addr_d = rd_done ? ((rd_pend_q || rd_load || rd_next >= TOP) ? '0 : rd_next)
              : (rd_load && !rd_active) ? '0 : rd_addr_q;
  end
  // State registers; last_served resets to read so the first contested grant is a write
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_rd_q <= 1'b1;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_rd_q <= last_rd_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
    end
  end
endmodule
